// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: fetch buffer entry, canonical NOP, default reset vector.
package riscv_pkg;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush. Data is readable the cycle after the push.
// When full, a push is accepted only alongside a pop. Flush overrides both push and pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push_vld,
  input  fetch_entry_t             i_push_dat,
  input  logic                     i_pop_rdy,
  output logic                     o_head_vld,
  output fetch_entry_t             o_head_dat,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_full;
  logic            w_pop;
  logic            w_push;

  assign w_full = (r_count == DEPTH[CW-1:0]);
  assign w_pop  = i_pop_rdy && (r_count != '0);
  assign w_push = i_push_vld && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_vld = (r_count != '0);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, fetch buffer, redirect flush.
// Fetch-to-valid latency 2 cycles; FETCH_PERF_EN adds delivered/stall counters.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [31:0]           stall_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  r_run;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_inflight_pc;

  logic                  w_req;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_head_vld;
  logic [CW-1:0]         w_count;
  logic [CW:0]           w_used;
  fetch_entry_t          w_push_dat;
  fetch_entry_t          w_head_dat;

  // A word leaving this cycle frees its slot, so streaming sustains one fetch per cycle.
  assign w_pop  = w_head_vld && instr_ready;
  assign w_used = {1'b0, w_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
  assign w_req  = r_run && !redirect && (w_used < FIFO_DEPTH[CW:0]);

  // A response landing on a redirect cycle belongs to the wrong path and is dropped.
  assign w_push           = r_inflight && !redirect;
  assign w_push_dat.instr = imem_rdata;
  assign w_push_dat.pc    = r_inflight_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run         <= 1'b0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_pc          <= {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_req;
      if (w_req) begin
        r_inflight_pc <= r_pc;
      end
      if (redirect) begin
        r_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      end else if (w_req) begin
        r_pc <= r_pc + ADDR_WIDTH'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (redirect),
    .i_push_vld (w_push),
    .i_push_dat (w_push_dat),
    .i_pop_rdy  (instr_ready),
    .o_head_vld (w_head_vld),
    .o_head_dat (w_head_dat),
    .o_count    (w_count)
  );

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign instr_valid = w_head_vld;
  assign instr       = w_head_dat.instr;
  assign instr_pc    = w_head_dat.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_head_vld && instr_ready) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_head_vld && !instr_ready) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, backpressure, redirects, PC wrap, async reset.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] EXP_PC [12] = '{
    32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C,
    32'h0000_0010, 32'h0000_0100, 32'h0000_0104, 32'h0000_0300,
    32'h0000_0304, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] log_pc[$];
  logic [31:0] log_instr[$];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  // Memory returns addr^KEY one cycle after a request, garbage otherwise.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      log_pc.push_back(instr_pc);
      log_instr.push_back(instr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #3;
  endtask

  task automatic expect_cyc(input string tag, input logic req, input logic [31:0] addr,
                            input logic vld, input logic [31:0] pc);
    chk({tag, ".req"}, 32'(imem_req), 32'(req));
    if (req) chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".vld"}, 32'(instr_valid), 32'(vld));
    if (vld) begin
      chk({tag, ".pc"}, instr_pc, pc);
      chk({tag, ".instr"}, instr, pc ^ KEY);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    nxt(); nxt(); #1;
    chk("rst.req",   32'(imem_req),    32'd0);
    chk("rst.vld",   32'(instr_valid), 32'd0);
    chk("rst.instr", instr,            32'd0);
    chk("rst.pc",    instr_pc,         32'd0);
`ifdef FETCH_PERF_EN
    chk("rst.fcnt", fetch_count, 32'd0);
    chk("rst.scnt", stall_count, 32'd0);
`endif
    rst_n = 1'b1;

    // Test 1: streaming from RESET_PC
    nxt(); #1; expect_cyc("t1.c0", 1'b1, 32'h0,  1'b0, 32'h0);
    nxt(); #1; expect_cyc("t1.c1", 1'b1, 32'h4,  1'b0, 32'h0);
    nxt(); #1; expect_cyc("t1.c2", 1'b1, 32'h8,  1'b1, 32'h0);
    nxt(); #1; expect_cyc("t1.c3", 1'b1, 32'hC,  1'b1, 32'h4);

    // Test 2: five stall cycles, head held at pc 8
    for (int i = 0; i < 5; i++) begin
      nxt(); instr_ready = 1'b0; #1;
      expect_cyc("t2.stall", 1'b0, 32'h0, 1'b1, 32'h8);
    end
    nxt(); instr_ready = 1'b1; #1; expect_cyc("t2.r0", 1'b1, 32'h10, 1'b1, 32'h8);
`ifdef FETCH_PERF_EN
    chk("t2.fcnt", fetch_count, 32'd2);
    chk("t2.scnt", stall_count, 32'd5);
`endif
    nxt(); #1; expect_cyc("t2.r1", 1'b1, 32'h14, 1'b1, 32'hC);

    // Test 3: redirect with one buffered and one in flight, handshake on same cycle
    nxt(); redirect = 1'b1; redirect_pc = 32'h100; #1;
    expect_cyc("t3.redir", 1'b0, 32'h0, 1'b1, 32'h10);
    nxt(); redirect = 1'b0; #1; expect_cyc("t3.c1", 1'b1, 32'h100, 1'b0, 32'h0);
`ifdef FETCH_PERF_EN
    chk("t3.fcnt", fetch_count, 32'd5);
`endif
    nxt(); #1; expect_cyc("t3.c2", 1'b1, 32'h104, 1'b0, 32'h0);
    nxt(); #1; expect_cyc("t3.c3", 1'b1, 32'h108, 1'b1, 32'h100);

    // Test 4: back-to-back redirects, last wins
    nxt(); redirect = 1'b1; redirect_pc = 32'h200; #1;
    expect_cyc("t4.r0", 1'b0, 32'h0, 1'b1, 32'h104);
    nxt(); redirect_pc = 32'h300; #1; expect_cyc("t4.r1", 1'b0, 32'h0, 1'b0, 32'h0);
    nxt(); redirect = 1'b0; #1;       expect_cyc("t4.c1", 1'b1, 32'h300, 1'b0, 32'h0);
    nxt(); #1; expect_cyc("t4.c2", 1'b1, 32'h304, 1'b0, 32'h0);
    nxt(); #1; expect_cyc("t4.c3", 1'b1, 32'h308, 1'b1, 32'h300);

    // Test 5: unaligned target near the top of memory, PC wraps to 0
    nxt(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFA; #1;
    expect_cyc("t5.r", 1'b0, 32'h0, 1'b1, 32'h304);
    nxt(); redirect = 1'b0; #1; expect_cyc("t5.c1", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
    nxt(); #1; expect_cyc("t5.c2", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    nxt(); #1; expect_cyc("t5.c3", 1'b1, 32'h0,         1'b1, 32'hFFFF_FFF8);
    nxt(); #1; expect_cyc("t5.c4", 1'b1, 32'h4,         1'b1, 32'hFFFF_FFFC);
    nxt(); #1; expect_cyc("t5.c5", 1'b1, 32'h8,         1'b1, 32'h0);

    // Test 6: asynchronous reset in the middle of a cycle
    nxt();
    rst_n = 1'b0; #1;
    chk("t6.req",   32'(imem_req),    32'd0);
    chk("t6.vld",   32'(instr_valid), 32'd0);
    chk("t6.instr", instr,            32'd0);
    chk("t6.pc",    instr_pc,         32'd0);
`ifdef FETCH_PERF_EN
    chk("t6.fcnt", fetch_count, 32'd0);
    chk("t6.scnt", stall_count, 32'd0);
`endif

    // Delivered stream so far: no stale, lost or duplicated words
    chk("log.size", 32'(log_pc.size()), 32'd12);
    for (int i = 0; i < 12 && i < log_pc.size(); i++) begin
      chk($sformatf("log.pc%0d", i),    log_pc[i],    EXP_PC[i]);
      chk($sformatf("log.instr%0d", i), log_instr[i], EXP_PC[i] ^ KEY);
    end

    nxt(); rst_n = 1'b1; #1; expect_cyc("t6.hold", 1'b0, 32'h0, 1'b0, 32'h0);
    nxt(); #1; expect_cyc("t6.c0", 1'b1, 32'h0, 1'b0, 32'h0);
    nxt(); #1; expect_cyc("t6.c1", 1'b1, 32'h4, 1'b0, 32'h0);
    nxt(); #1; expect_cyc("t6.c2", 1'b1, 32'h8, 1'b1, 32'h0);
`ifdef FETCH_PERF_EN
    chk("t6.fcnt2", fetch_count, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
